alu_pair_issue: RTL and testbench
=================================

// Module: alu_pair_issue
// PURPOSE
//  Issue-side producer for the dual-ALU wrapper. Takes up to two decoded ALU ops per
//  cycle (in order: slot0 older, slot1 younger), registers them, steers them onto ALU
//  lanes, and drives per-lane operation/operands plus rs1/rs2_from_rd bypass flags.
//  Pairs the wrapper cannot execute together are split across two cycles, and the older
//  lane-0 result is captured and forwarded into the younger op.
// PARAMETERS
//  XLEN        64  operand/result width
//  OP_BITS     8   width of encoded ALU operation
//  TRANS_ID_W  3   scoreboard transaction id width
//  REG_W       5   architectural register index width
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           synchronous active-high reset
//  flush_i       in   1           drop all held ops (sync, same priority as reset on state)
//  in_valid_i    in   2           per-slot op valid; slot1 valid only if slot0 valid
//  in_ready_o    out  1           pair accepted when in_valid_i[0] && in_ready_o
//  in_op_i       in   2xOP_BITS   operation per slot
//  in_opa_i      in   2xXLEN      operand_a per slot (regfile/imm value)
//  in_opb_i      in   2xXLEN      operand_b per slot
//  in_rs1_i      in   2xREG_W     rs1 index per slot
//  in_rs2_i      in   2xREG_W     rs2 index per slot
//  in_rd_i       in   2xREG_W     rd index per slot
//  in_we_i       in   2           slot writes rd
//  in_branch_i   in   2           slot is a branch (lane 0 only)
//  in_tid_i      in   2xTRANS_ID_W trans id per slot
//  out_valid_o   out  2           lane valid (lane0 = index 0)
//  out_ready_i   in   1           downstream consumes both lanes this cycle
//  out_op_o      out  2xOP_BITS   lane operation
//  out_opa_o     out  2xXLEN      lane operand_a
//  out_opb_o     out  2xXLEN      lane operand_b
//  out_tid_o     out  2xTRANS_ID_W lane trans id
//  rs1_from_rd_o out  1           lane0 operand_a taken from lane1 result
//  rs2_from_rd_o out  1           lane0 operand_b taken from lane1 result
//  alu_result0_i in   XLEN        lane-0 ALU result, valid in cycle of issue
// BEHAVIOUR
//  - Reset/flush: state EMPTY; out_valid_o=0, rs1/rs2_from_rd_o=0, in_ready_o=1 next cycle;
//    all other outputs 0. Flush mid-SPLIT discards the held younger op; no partial issue.
//  - dep1 = in_we_i[0] && in_rd_i[0]!=0 && in_rs1_i[1]==in_rd_i[0]; dep2 likewise on rs2.
//  - States: EMPTY, ISSUE (output reg holds pair/single), SPLIT1 (older on lane0,
//    younger held), SPLIT2 (younger on lane0).
//  - Accept (in_valid_i[0] && in_ready_o): 1-cycle latency to out_valid_o.
//    * single (in_valid_i=01): lane0=slot0, flags 0 -> ISSUE.
//    * pair, !in_branch_i[0]: lane1=slot0 (older), lane0=slot1, flags=dep1/dep2 -> ISSUE.
//    * pair, in_branch_i[0] (older branch): lane0=slot0 alone -> SPLIT1; younger plus
//      dep1/dep2 held in shadow reg.
//    * in_branch_i[1] with !in_branch_i[0] is a legal pair (younger lands on lane0).
//    * both branches: split as above; younger issues on lane0 in SPLIT2.
//  - in_ready_o = (state==EMPTY) || (state==ISSUE && out_ready_i). Never 1 in SPLIT1/SPLIT2.
//  - Outputs hold stable while out_valid_o!=0 && !out_ready_i.
//  - SPLIT1 & out_ready_i: capture alu_result0_i; -> SPLIT2. Younger's operand_a replaced by
//    captured value if dep1, operand_b if dep2; rs*_from_rd_o=0 in SPLIT2.
//  - SPLIT2 & out_ready_i -> EMPTY (in_ready_o=0 that cycle; no back-to-back accept).
//  - ISSUE & out_ready_i & new accept -> ISSUE with new contents (full throughput).
//  - ISSUE & out_ready_i & no accept -> EMPTY.
//  - in_valid_i=10 is illegal (assert); rd=x0 never produces a bypass.
//  - flush_i has priority over out_ready_i and accept in the same cycle.
// TESTING
//  - reset held 2 cycles -> out_valid_o=00, flags 0, in_ready_o=1 after release.
//  - pair add x5<-x1+x2; add x6<-x5+x3 -> next cycle out_valid_o=11, lane1 tid=slot0,
//    rs1_from_rd_o=1, rs2_from_rd_o=0.
//  - pair, slot0 rd=x0, slot1 rs1=x0 -> rs1_from_rd_o=0.
//  - older beq + younger dependent add (rs2=rd=x7, we=1), alu_result0_i=0x1234 in SPLIT1 ->
//    SPLIT2 lane0 opb=0x1234, out_valid_o=01, in_ready_o=0 for 2 cycles.
//  - out_ready_i=0 for 3 cycles in ISSUE -> outputs stable, in_ready_o=0; then streaming
//    pairs each cycle with out_ready_i=1 -> one pair per cycle.
//  - flush_i in SPLIT1 -> next cycle out_valid_o=00, EMPTY, held younger never issued.

Source files
------------

// File: rtl/alu_pair_issue.sv
// alu_pair_issue: issue-side producer for the dual-ALU wrapper.
// Accepts up to two in-order decoded ALU ops per cycle (slot0 older), registers
// them onto ALU lanes and drives the lane0 bypass flags. An older branch forces
// a split issue. In that case the older lane-0 result is captured and forwarded
// into the held younger op.
//
// Ports:
//   clk_i, rst_i, flush_i           clock, sync active-high reset, sync flush
//   in_valid_i/in_ready_o           per-slot input valid, pair-level ready
//   in_op/opa/opb/rs1/rs2/rd/we/branch/tid_i   per-slot decoded op fields
//   out_valid_o/out_ready_i         per-lane valid, downstream consumes both lanes
//   out_op/opa/opb/tid_o            per-lane operation payload
//   rs1_from_rd_o/rs2_from_rd_o     lane0 operand_a/b comes from the lane1 result
//   alu_result0_i                   lane-0 ALU result in its issue cycle
module alu_pair_issue #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned OP_BITS    = 8,
    parameter int unsigned TRANS_ID_W = 3,
    parameter int unsigned REG_W      = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [1:0]                 in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0][OP_BITS-1:0]    in_op_i,
    input  logic [1:0][XLEN-1:0]       in_opa_i,
    input  logic [1:0][XLEN-1:0]       in_opb_i,
    input  logic [1:0][REG_W-1:0]      in_rs1_i,
    input  logic [1:0][REG_W-1:0]      in_rs2_i,
    input  logic [1:0][REG_W-1:0]      in_rd_i,
    input  logic [1:0]                 in_we_i,
    input  logic [1:0]                 in_branch_i,
    input  logic [1:0][TRANS_ID_W-1:0] in_tid_i,
    output logic [1:0]                 out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0][OP_BITS-1:0]    out_op_o,
    output logic [1:0][XLEN-1:0]       out_opa_o,
    output logic [1:0][XLEN-1:0]       out_opb_o,
    output logic [1:0][TRANS_ID_W-1:0] out_tid_o,
    output logic                       rs1_from_rd_o,
    output logic                       rs2_from_rd_o,
    input  logic [XLEN-1:0]            alu_result0_i
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SPLIT1 = 2'd2,
        ST_SPLIT2 = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_BITS-1:0]    op;
        logic [XLEN-1:0]       opa;
        logic [XLEN-1:0]       opb;
        logic [TRANS_ID_W-1:0] tid;
    } lane_t;

    state_e        state_q, state_d;
    logic [1:0]    valid_q, valid_d;
    lane_t [1:0]   lane_q, lane_d;
    logic          rs1_q, rs1_d;
    logic          rs2_q, rs2_d;
    lane_t         shd_q, shd_d;
    logic          shd_dep1_q, shd_dep1_d;
    logic          shd_dep2_q, shd_dep2_d;

    lane_t [1:0]   slot_c;
    logic          dep1_c, dep2_c, accept_c, load_c, clear_c;
    logic          unused_inputs_c;

    // Fields only meaningful for one slot position.
    assign unused_inputs_c = ^{in_rs1_i[0], in_rs2_i[0], in_rd_i[1], in_we_i[1], in_branch_i[1]};

    // Pack incoming slots into lane payloads.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_c[i].op  = in_op_i[i];
            slot_c[i].opa = in_opa_i[i];
            slot_c[i].opb = in_opb_i[i];
            slot_c[i].tid = in_tid_i[i];
        end
    end

    // Younger-on-older RAW hazards; writes to x0 never forward.
    assign dep1_c = in_we_i[0] && (in_rd_i[0] != '0) && (in_rs1_i[1] == in_rd_i[0]);
    assign dep2_c = in_we_i[0] && (in_rd_i[0] != '0) && (in_rs2_i[1] == in_rd_i[0]);

    assign in_ready_o = (state_q == ST_EMPTY) || ((state_q == ST_ISSUE) && out_ready_i);
    assign accept_c   = in_valid_i[0] && in_ready_o;

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        lane_d     = lane_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        shd_d      = shd_q;
        shd_dep1_d = shd_dep1_q;
        shd_dep2_d = shd_dep2_q;
        load_c     = 1'b0;
        clear_c    = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                load_c = accept_c;
            end
            ST_ISSUE: begin
                if (out_ready_i) begin
                    load_c  = accept_c;
                    clear_c = !accept_c;
                end
            end
            ST_SPLIT1: begin
                // Older op consumed: its result is on alu_result0_i this cycle.
                if (out_ready_i) begin
                    state_d        = ST_SPLIT2;
                    valid_d        = 2'b01;
                    lane_d[1]      = '0;
                    lane_d[0]      = shd_q;
                    if (shd_dep1_q) lane_d[0].opa = alu_result0_i;
                    if (shd_dep2_q) lane_d[0].opb = alu_result0_i;
                    rs1_d          = 1'b0;
                    rs2_d          = 1'b0;
                end
            end
            ST_SPLIT2: begin
                clear_c = out_ready_i;
            end
            default: begin
                clear_c = 1'b1;
            end
        endcase

        if (clear_c) begin
            state_d = ST_EMPTY;
            valid_d = 2'b00;
            lane_d  = '0;
            rs1_d   = 1'b0;
            rs2_d   = 1'b0;
        end

        if (load_c) begin
            if (!in_valid_i[1]) begin
                state_d   = ST_ISSUE;
                valid_d   = 2'b01;
                lane_d[0] = slot_c[0];
                lane_d[1] = '0;
                rs1_d     = 1'b0;
                rs2_d     = 1'b0;
            end else if (!in_branch_i[0]) begin
                // Older rides lane1 so its result can bypass into lane0.
                state_d   = ST_ISSUE;
                valid_d   = 2'b11;
                lane_d[1] = slot_c[0];
                lane_d[0] = slot_c[1];
                rs1_d     = dep1_c;
                rs2_d     = dep2_c;
            end else begin
                // Older branch must own lane0; younger waits in the shadow reg.
                state_d    = ST_SPLIT1;
                valid_d    = 2'b01;
                lane_d[0]  = slot_c[0];
                lane_d[1]  = '0;
                rs1_d      = 1'b0;
                rs2_d      = 1'b0;
                shd_d      = slot_c[1];
                shd_dep1_d = dep1_c;
                shd_dep2_d = dep2_c;
            end
        end

        if (flush_i) begin
            state_d    = ST_EMPTY;
            valid_d    = 2'b00;
            lane_d     = '0;
            rs1_d      = 1'b0;
            rs2_d      = 1'b0;
            shd_d      = '0;
            shd_dep1_d = 1'b0;
            shd_dep2_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            valid_q    <= 2'b00;
            lane_q     <= '0;
            rs1_q      <= 1'b0;
            rs2_q      <= 1'b0;
            shd_q      <= '0;
            shd_dep1_q <= 1'b0;
            shd_dep2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            lane_q     <= lane_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            shd_q      <= shd_d;
            shd_dep1_q <= shd_dep1_d;
            shd_dep2_q <= shd_dep2_d;
        end
    end

    // A younger slot without an older one is a decoder bug.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (in_valid_i != 2'b10);
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            out_op_o[i]  = lane_q[i].op;
            out_opa_o[i] = lane_q[i].opa;
            out_opb_o[i] = lane_q[i].opb;
            out_tid_o[i] = lane_q[i].tid;
        end
    end

    assign out_valid_o   = valid_q;
    assign rs1_from_rd_o = rs1_q;
    assign rs2_from_rd_o = rs2_q;

endmodule

// File: tb/tb_alu_pair_issue.sv
module tb_alu_pair_issue;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned OP_BITS    = 8;
    localparam int unsigned TRANS_ID_W = 3;
    localparam int unsigned REG_W      = 5;

    logic                       clk = 1'b0;
    logic                       rst_i;
    logic                       flush_i;
    logic [1:0]                 in_valid_i;
    logic                       in_ready_o;
    logic [1:0][OP_BITS-1:0]    in_op_i;
    logic [1:0][XLEN-1:0]       in_opa_i;
    logic [1:0][XLEN-1:0]       in_opb_i;
    logic [1:0][REG_W-1:0]      in_rs1_i;
    logic [1:0][REG_W-1:0]      in_rs2_i;
    logic [1:0][REG_W-1:0]      in_rd_i;
    logic [1:0]                 in_we_i;
    logic [1:0]                 in_branch_i;
    logic [1:0][TRANS_ID_W-1:0] in_tid_i;
    logic [1:0]                 out_valid_o;
    logic                       out_ready_i;
    logic [1:0][OP_BITS-1:0]    out_op_o;
    logic [1:0][XLEN-1:0]       out_opa_o;
    logic [1:0][XLEN-1:0]       out_opb_o;
    logic [1:0][TRANS_ID_W-1:0] out_tid_o;
    logic                       rs1_from_rd_o;
    logic                       rs2_from_rd_o;
    logic [XLEN-1:0]            alu_result0_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pair_issue #(
        .XLEN(XLEN), .OP_BITS(OP_BITS), .TRANS_ID_W(TRANS_ID_W), .REG_W(REG_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_op_i(in_op_i), .in_opa_i(in_opa_i), .in_opb_i(in_opb_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
        .in_we_i(in_we_i), .in_branch_i(in_branch_i), .in_tid_i(in_tid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_op_o(out_op_o), .out_opa_o(out_opa_o), .out_opb_o(out_opb_o),
        .out_tid_o(out_tid_o), .rs1_from_rd_o(rs1_from_rd_o),
        .rs2_from_rd_o(rs2_from_rd_o), .alu_result0_i(alu_result0_i)
    );

    task automatic set_slot(input int s, input logic [7:0] op, input logic [63:0] opa,
                            input logic [63:0] opb, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic we, input logic br,
                            input logic [2:0] tid);
        in_op_i[s]     = op;
        in_opa_i[s]    = opa;
        in_opb_i[s]    = opb;
        in_rs1_i[s]    = rs1;
        in_rs2_i[s]    = rs2;
        in_rd_i[s]     = rd;
        in_we_i[s]     = we;
        in_branch_i[s] = br;
        in_tid_i[s]    = tid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 2'b00; out_ready_i = 1'b0;
        alu_result0_i = '0;
        set_slot(0, 8'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        set_slot(1, 8'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        step();
        step();
        rst_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b exp 00", out_valid_o); end
        checks++; if ({rs1_from_rd_o, rs2_from_rd_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b exp 00", rs1_from_rd_o, rs2_from_rd_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready_o); end
        checks++; if (out_opa_o[0] !== 64'h0) begin errors++; $display("FAIL reset_opa: got %0h exp 0", out_opa_o[0]); end
    endtask

    task automatic test_pair_bypass();
        out_ready_i = 1'b1;
        set_slot(0, 8'h01, 64'd10, 64'd20, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 3'd3);
        set_slot(1, 8'h01, 64'hAA, 64'd30, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 3'd4);
        in_valid_i = 2'b11;
        step();
        in_valid_i = 2'b00;
        checks++; if (out_valid_o !== 2'b11) begin errors++; $display("FAIL pair_valid: got %b exp 11", out_valid_o); end
        checks++; if (out_tid_o[1] !== 3'd3) begin errors++; $display("FAIL pair_tid1: got %0d exp 3", out_tid_o[1]); end
        checks++; if (out_tid_o[0] !== 3'd4) begin errors++; $display("FAIL pair_tid0: got %0d exp 4", out_tid_o[0]); end
        checks++; if (rs1_from_rd_o !== 1'b1) begin errors++; $display("FAIL pair_rs1: got %b exp 1", rs1_from_rd_o); end
        checks++; if (rs2_from_rd_o !== 1'b0) begin errors++; $display("FAIL pair_rs2: got %b exp 0", rs2_from_rd_o); end
        checks++; if (out_opa_o[1] !== 64'd10) begin errors++; $display("FAIL pair_opa1: got %0h exp a", out_opa_o[1]); end
        checks++; if (out_opb_o[0] !== 64'd30) begin errors++; $display("FAIL pair_opb0: got %0h exp 1e", out_opb_o[0]); end
        step();
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL pair_drain: got %b exp 00", out_valid_o); end
    endtask

    task automatic test_x0();
        set_slot(0, 8'h01, 64'd1, 64'd2, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 3'd1);
        set_slot(1, 8'h01, 64'd3, 64'd4, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 3'd2);
        in_valid_i = 2'b11;
        step();
        in_valid_i = 2'b00;
        checks++; if (out_valid_o !== 2'b11) begin errors++; $display("FAIL x0_valid: got %b exp 11", out_valid_o); end
        checks++; if ({rs1_from_rd_o, rs2_from_rd_o} !== 2'b00) begin errors++; $display("FAIL x0_flags: got %b%b exp 00", rs1_from_rd_o, rs2_from_rd_o); end
        step();
    endtask

    task automatic test_split();
        out_ready_i = 1'b1;
        set_slot(0, 8'h20, 64'd1, 64'd2, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 3'd1);
        set_slot(1, 8'h01, 64'h55, 64'hDEAD, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 3'd2);
        in_valid_i = 2'b11;
        step();
        in_valid_i = 2'b00;
        alu_result0_i = 64'h1234;
        checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL split1_valid: got %b exp 01", out_valid_o); end
        checks++; if (out_op_o[0] !== 8'h20 || out_tid_o[0] !== 3'd1) begin errors++; $display("FAIL split1_lane0: got op %0h tid %0d exp op 20 tid 1", out_op_o[0], out_tid_o[0]); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL split1_ready: got %b exp 0", in_ready_o); end
        step();
        alu_result0_i = 64'h0;
        in_valid_i = 2'b01;
        set_slot(0, 8'h03, 64'd9, 64'd9, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 3'd5);
        checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL split2_valid: got %b exp 01", out_valid_o); end
        checks++; if (out_opb_o[0] !== 64'h1234) begin errors++; $display("FAIL split2_opb: got %0h exp 1234", out_opb_o[0]); end
        checks++; if (out_opa_o[0] !== 64'h55 || out_tid_o[0] !== 3'd2) begin errors++; $display("FAIL split2_lane0: got opa %0h tid %0d exp 55 2", out_opa_o[0], out_tid_o[0]); end
        checks++; if ({rs1_from_rd_o, rs2_from_rd_o} !== 2'b00) begin errors++; $display("FAIL split2_flags: got %b%b exp 00", rs1_from_rd_o, rs2_from_rd_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL split2_ready: got %b exp 0", in_ready_o); end
        step();
        in_valid_i = 2'b00;
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL split_no_b2b: got %b exp 00", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        set_slot(0, 8'h02, 64'h100, 64'h101, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 3'd0);
        set_slot(1, 8'h02, 64'h200, 64'h201, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 3'd1);
        in_valid_i = 2'b11;
        step();
        // Offer the next pair while downstream stalls.
        set_slot(0, 8'h04, 64'h300, 64'h301, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 3'd2);
        set_slot(1, 8'h04, 64'h400, 64'h401, 5'd12, 5'd4, 5'd13, 1'b1, 1'b1, 3'd3);
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid_o !== 2'b11 || out_tid_o[1] !== 3'd0 || out_tid_o[0] !== 3'd1 || out_opa_o[0] !== 64'h200) begin
                errors++; $display("FAIL stall_hold[%0d]: got v %b tid %0d/%0d opa0 %0h exp 11 0/1 200", c, out_valid_o, out_tid_o[1], out_tid_o[0], out_opa_o[0]);
            end
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b exp 0", c, in_ready_o); end
            step();
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b exp 1", in_ready_o); end
        step();
        checks++; if (out_valid_o !== 2'b11 || out_tid_o[1] !== 3'd2 || out_tid_o[0] !== 3'd3 || rs1_from_rd_o !== 1'b1) begin
            errors++; $display("FAIL stream_p1: got v %b tid %0d/%0d rs1 %b exp 11 2/3 1", out_valid_o, out_tid_o[1], out_tid_o[0], rs1_from_rd_o);
        end
        set_slot(0, 8'h05, 64'h500, 64'h501, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 3'd4);
        set_slot(1, 8'h05, 64'h600, 64'h601, 5'd3, 5'd4, 5'd15, 1'b1, 1'b0, 3'd5);
        step();
        checks++; if (out_valid_o !== 2'b11 || out_tid_o[1] !== 3'd4 || out_tid_o[0] !== 3'd5 || out_opb_o[0] !== 64'h601 || rs1_from_rd_o !== 1'b0) begin
            errors++; $display("FAIL stream_p2: got v %b tid %0d/%0d opb0 %0h rs1 %b exp 11 4/5 601 0", out_valid_o, out_tid_o[1], out_tid_o[0], out_opb_o[0], rs1_from_rd_o);
        end
        in_valid_i = 2'b00;
        step();
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL stream_drain: got %b exp 00", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b1;
        set_slot(0, 8'h20, 64'd1, 64'd2, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 3'd6);
        set_slot(1, 8'h21, 64'h77, 64'h88, 5'd7, 5'd3, 5'd8, 1'b1, 1'b1, 3'd7);
        in_valid_i = 2'b11;
        step();
        in_valid_i = 2'b00;
        checks++; if (out_valid_o !== 2'b01 || out_tid_o[0] !== 3'd6) begin errors++; $display("FAIL flush_pre: got v %b tid %0d exp 01 6", out_valid_o, out_tid_o[0]); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b exp 00", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", in_ready_o); end
        step();
        checks++; if (out_valid_o !== 2'b00 || out_tid_o[0] !== 3'd0) begin errors++; $display("FAIL flush_no_younger: got v %b tid %0d exp 00 0", out_valid_o, out_tid_o[0]); end
    endtask

    initial begin
        test_reset();
        test_pair_bypass();
        test_x0();
        test_split();
        test_back_to_back();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
